// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants and types for the Smith-Waterman array feeder
// Purpose: character encoding, feeder FSM state type and the score width
//          shared with sw_pe.
// Ports:   none (package)
package sw_pkg;

  // 2-bit nucleotide encoding used throughout the array
  localparam logic [1:0] CHAR_A = 2'd0;
  localparam logic [1:0] CHAR_C = 2'd1;
  localparam logic [1:0] CHAR_G = 2'd2;
  localparam logic [1:0] CHAR_T = 2'd3;

  // Score width shared with sw_pe
  localparam int SCORE_W = 16;

  // FIFO entry layout: {last, char}
  localparam int ENTRY_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    CLEAR  = 2'd3
  } feed_state_t;

  function automatic logic [ENTRY_W-1:0] pack_entry(input logic last, input logic [1:0] ch);
    return {last, ch};
  endfunction

endpackage

// File: rtl/sw_seq_feeder_if.sv
// rtl/sw_seq_feeder_if.sv - host load port of the sequence feeder
// Purpose: groups the host character write handshake.
// Signals: in_char (2b character), in_last (final char of sequence),
//          in_valid (host write request), in_ready (feeder can accept).
//          Transfer occurs when in_valid && in_ready.
interface sw_seq_feeder_if;
  logic [1:0] in_char;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_char,
    output in_last,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_char,
    input  in_last,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/sw_char_fifo.sv
// rtl/sw_char_fifo.sv - DEPTH x WIDTH synchronous FIFO with full/empty flags
// Purpose: buffers {last, char} entries between the host and the feeder FSM.
// Ports:   clk, rst_n (async active-low), push/push_data (write, ignored when
//          full), pop/pop_data (read, ignored when empty; pop_data shows the
//          head entry combinationally), full, empty.
module sw_char_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sw_seq_feeder.sv
// rtl/sw_seq_feeder.sv - transmit end of the systolic Smith-Waterman stream
// Purpose: buffers host characters, feeds PE[0] one character per cycle,
//          waits for the final character to traverse the array, then pulses
//          an array clear and a sequence-done flag.
// Ports:   clk, rst_n (async active-low)
//          host        : load port (in_char/in_last/in_valid/in_ready)
//          en_i        : stream enable, 0 inserts bubbles
//          Y_o/valid_o/last_o : character stream to PE[0]
//          pe_clr_o    : one-cycle synchronous clear to every PE
//          seq_done_o  : one-cycle pulse, final score valid at array output
//          char_cnt_o  : characters sent in the current sequence (saturating)
//          busy_o      : FSM not idle
module sw_seq_feeder
  import sw_pkg::*;
#(
  parameter int NUM_PE = 16,
  parameter int DEPTH  = 16,
  parameter int LEN_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  sw_seq_feeder_if.slave   host,
  input  logic             en_i,
  output logic [1:0]       Y_o,
  output logic             valid_o,
  output logic             last_o,
  output logic             pe_clr_o,
  output logic             seq_done_o,
  output logic [LEN_W-1:0] char_cnt_o,
  output logic             busy_o
);

  localparam int DW = $clog2(NUM_PE + 1);

  feed_state_t        state;
  logic [DW-1:0]      drain_cnt;
  logic               ready_en;
  logic               fifo_full;
  logic               fifo_empty;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  // ready_en keeps in_ready low while reset is asserted even though the
  // FIFO count reads empty then.
  assign host.in_ready = ready_en && !fifo_full;
  assign pop           = (state == STREAM) && !fifo_empty && en_i;
  assign busy_o        = (state != IDLE);

  sw_char_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (host.in_valid && host.in_ready),
    .push_data (pack_entry(host.in_last, host.in_char)),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      drain_cnt  <= '0;
      Y_o        <= '0;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      pe_clr_o   <= 1'b0;
      seq_done_o <= 1'b0;
      char_cnt_o <= '0;
    end else begin
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      pe_clr_o   <= 1'b0;
      seq_done_o <= 1'b0;

      case (state)
        IDLE: begin
          if (!fifo_empty) state <= STREAM;
        end

        STREAM: begin
          // Y_o holds across bubbles; the PEs ignore it while valid is low.
          if (pop) begin
            Y_o     <= head[1:0];
            valid_o <= 1'b1;
            last_o  <= head[2];
            if (char_cnt_o != {LEN_W{1'b1}}) char_cnt_o <= char_cnt_o + 1'b1;
            if (head[2]) begin
              state     <= DRAIN;
              drain_cnt <= DW'(NUM_PE);
            end
          end
        end

        DRAIN: begin
          // The first DRAIN cycle is the one presenting the final character
          // to PE[0]; the NUM_PE cycles after it carry it through the array.
          if (drain_cnt == '0) state <= CLEAR;
          else                 drain_cnt <= drain_cnt - 1'b1;
        end

        CLEAR: begin
          pe_clr_o   <= 1'b1;
          seq_done_o <= 1'b1;
          char_cnt_o <= '0;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_seq_feeder.sv
// tb/tb_sw_seq_feeder.sv - scoreboard testbench for sw_seq_feeder
module tb_sw_seq_feeder;
  import sw_pkg::*;

  localparam int NUM_PE = 4;
  localparam int DEPTH  = 16;
  localparam int LEN_W  = 16;

  logic             clk;
  logic             rst_n;
  logic             en_i;
  logic             en_main;
  logic             tog;
  logic             bubble_mode;
  logic [1:0]       Y_o;
  logic             valid_o;
  logic             last_o;
  logic             pe_clr_o;
  logic             seq_done_o;
  logic [LEN_W-1:0] char_cnt_o;
  logic             busy_o;

  sw_seq_feeder_if bus ();

  sw_seq_feeder #(
    .NUM_PE (NUM_PE),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .host       (bus),
    .en_i       (en_i),
    .Y_o        (Y_o),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .pe_clr_o   (pe_clr_o),
    .seq_done_o (seq_done_o),
    .char_cnt_o (char_cnt_o),
    .busy_o     (busy_o)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [2:0] exp_q[$];
  int         len_q[$];
  int         done_q[$];
  int         v_cyc[$];
  int         cur_len = 0;
  bit         draining = 0;
  int         done_seen = 0;
  int         clr_seen = 0;
  int         vseen = 0;
  int         acc_cnt = 0;
  bit         sender_done = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  assign en_i = bubble_mode ? tog : en_main;

  always @(posedge clk) begin
    cyc++;
    #1 tog = ~tog;
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a character.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) acc_cnt++;
      if (valid_o) begin
        vseen++;
        v_cyc.push_back(cyc);
        if (draining) check("valid_during_drain", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", 1, 0);
        end else begin
          logic [2:0] e;
          e = exp_q.pop_front();
          check("y_o", int'(Y_o), int'(e[1:0]));
          check("last_o", int'(last_o), int'(e[2]));
          if (last_o) begin
            if (len_q.size() != 0) check("char_cnt_at_last", int'(char_cnt_o), len_q.pop_front());
            done_q.push_back(cyc + NUM_PE + 2);
            draining = 1;
          end
        end
      end else if (last_o) begin
        check("last_without_valid", 1, 0);
      end
      if (seq_done_o || pe_clr_o) begin
        clr_seen++;
        if (seq_done_o) done_seen++;
        check("clr_eq_done", int'(pe_clr_o), int'(seq_done_o));
        if (done_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_cycle", cyc, done_q.pop_front());
          check("char_cnt_cleared", int'(char_cnt_o), 0);
        end
        draining = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] c, input logic l);
    int guard = 0;
    bus.in_char  = c;
    bus.in_last  = l;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 2000) check("send_timeout", 0, 1);
    exp_q.push_back({l, c});
    cur_len++;
    if (l) begin
      len_q.push_back(cur_len);
      cur_len = 0;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int guard = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0 || draining || busy_o) && guard < 1000) begin
      tick(1);
      guard++;
    end
    if (guard >= 1000) check({name, "_timeout"}, 0, 1);
    tick(2);
  endtask

  int d0;

  initial begin
    rst_n        = 1'b0;
    en_main      = 1'b0;
    tog          = 1'b0;
    bubble_mode  = 1'b0;
    bus.in_char  = 2'd0;
    bus.in_last  = 1'b0;
    bus.in_valid = 1'b0;

    // Reset state
    tick(3);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_valid", int'(valid_o), 0);
    check("rst_busy", int'(busy_o), 0);
    check("rst_char_cnt", int'(char_cnt_o), 0);
    rst_n = 1'b1;
    tick(2);
    check("post_rst_in_ready", int'(bus.in_ready), 1);

    // Reset mid-stream with 5 characters buffered
    for (int i = 0; i < 5; i++) send(2'(i), 1'b0);
    tick(2);
    check("buffered_busy", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(bus.in_ready), 0);
    check("midrst_valid", int'(valid_o), 0);
    check("midrst_last", int'(last_o), 0);
    check("midrst_clr", int'(pe_clr_o), 0);
    check("midrst_done", int'(seq_done_o), 0);
    check("midrst_busy", int'(busy_o), 0);
    check("midrst_char_cnt", int'(char_cnt_o), 0);
    check("midrst_y", int'(Y_o), 0);
    exp_q.delete();
    len_q.delete();
    cur_len = 0;
    @(posedge clk);
    #3;
    rst_n   = 1'b1;
    en_main = 1'b1;
    vseen    = 0;
    clr_seen = 0;
    tick(12);
    check("rel_in_ready", int'(bus.in_ready), 1);
    check("rel_busy", int'(busy_o), 0);
    check("rel_no_valid", vseen, 0);
    check("rel_no_clr", clr_seen, 0);

    // Single sequence G,A,T,T
    v_cyc.delete();
    send(CHAR_G, 1'b0);
    send(CHAR_A, 1'b0);
    send(CHAR_T, 1'b0);
    send(CHAR_T, 1'b1);
    wait_idle("single");
    check("single_nvalid", v_cyc.size(), 4);
    if (v_cyc.size() == 4) check("single_consecutive", v_cyc[3] - v_cyc[0], 3);

    // Bubbles: en_i alternates during a 6-character sequence
    v_cyc.delete();
    bubble_mode = 1'b1;
    send(CHAR_T, 1'b0);
    send(CHAR_C, 1'b0);
    send(CHAR_A, 1'b0);
    send(CHAR_G, 1'b0);
    send(CHAR_G, 1'b0);
    send(CHAR_C, 1'b1);
    wait_idle("bubble");
    bubble_mode = 1'b0;
    check("bubble_nvalid", v_cyc.size(), 6);
    if (v_cyc.size() == 6) check("bubble_spacing", v_cyc[5] - v_cyc[0], 10);

    // Full buffer: 20 back-to-back pushes with streaming stalled
    en_main     = 1'b0;
    acc_cnt     = 0;
    sender_done = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) send(2'((i * 3 + 1) % 4), (i == 19));
        sender_done = 1;
      end
    join_none
    tick(40);
    check("full_accepts", acc_cnt, 16);
    check("full_in_ready", int'(bus.in_ready), 0);
    en_main = 1'b1;
    begin
      int guard = 0;
      while (!sender_done && guard < 500) begin
        tick(1);
        guard++;
      end
      check("full_sender_done", int'(sender_done), 1);
    end
    wait_idle("full");
    check("full_total_accepts", acc_cnt, 20);

    // Back-to-back sequences A (3 chars) and B (2 chars)
    d0 = done_seen;
    send(CHAR_A, 1'b0);
    send(CHAR_C, 1'b0);
    send(CHAR_G, 1'b1);
    send(CHAR_T, 1'b0);
    send(CHAR_A, 1'b1);
    wait_idle("b2b");
    check("b2b_done_count", done_seen - d0, 2);

    // One-character sequence
    v_cyc.delete();
    d0 = done_seen;
    send(CHAR_C, 1'b1);
    wait_idle("one");
    check("one_nvalid", v_cyc.size(), 1);
    check("one_done_count", done_seen - d0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
